// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: N-master arbiter for the native memory bus.
// Round-robin or fixed-priority selection, one owner at a time, owner
// index exported on currmaster. Optional stall-timeout abort is built
// when the macro ARB_TIMEOUT_EN is defined.
module mem_arbiter_rr #(
   parameter int MASTER_CNT     = 2,
   parameter int PRIO_MODE      = 0,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    clk48m,
   input  logic                    resetn,
   input  logic [MASTER_CNT-1:0]   m_valid,
   input  logic [32*MASTER_CNT-1:0] m_addr,
   input  logic [32*MASTER_CNT-1:0] m_wdata,
   input  logic [4*MASTER_CNT-1:0] m_wstrb,
   output logic [MASTER_CNT-1:0]   m_ready,
   output logic [31:0]             m_rdata,
   output logic                    s_valid,
   output logic [31:0]             s_addr,
   output logic [31:0]             s_wdata,
   output logic [3:0]              s_wstrb,
   input  logic                    s_ready,
   input  logic [31:0]             s_rdata,
   output logic [31:0]             currmaster,
   output logic                    bus_timeout
);

   localparam int GW = (MASTER_CNT > 1) ? $clog2(MASTER_CNT) : 1;
   localparam logic [GW:0]   CNT_W  = (GW+1)'(MASTER_CNT);
   localparam logic [GW-1:0] LAST_M = GW'(MASTER_CNT - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] GRANT = 2'd1;
`ifdef ARB_TIMEOUT_EN
   localparam logic [1:0]  ABORT    = 2'd2;
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
`endif

   if (MASTER_CNT < 1 || MASTER_CNT > 16 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
      $error("mem_arbiter_rr: parameter out of range");
   end

   logic [1:0]      state;
   logic [GW-1:0]   ptr;
   logic [GW-1:0]   g;
   logic [GW-1:0]   win;
   logic            any_req;
   logic            sel_valid;
   logic [31:0]     sel_addr;
   logic [31:0]     sel_wdata;
   logic [3:0]      sel_wstrb;

   // Winner search: scan from ptr (round-robin) or from 0 (fixed priority)
   always_comb begin
      logic [GW:0]           sum;
      logic [MASTER_CNT-1:0] sh;
      win     = '0;
      any_req = 1'b0;
      sum     = '0;
      sh      = '0;
      for (int i = 0; i < MASTER_CNT; i++) begin
         sum = (PRIO_MODE != 0) ? (GW+1)'(i) : ({1'b0, ptr} + (GW+1)'(i));
         if (sum >= CNT_W) sum = sum - CNT_W;
         sh = m_valid >> sum[GW-1:0];
         if (!any_req && sh[0]) begin
            any_req = 1'b1;
            win     = sum[GW-1:0];
         end
      end
   end

   // Slice mux for the current owner
   always_comb begin
      sel_valid = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_wstrb = '0;
      for (int i = 0; i < MASTER_CNT; i++) begin
         if (GW'(i) == g) begin
            sel_valid = m_valid[i];
            sel_addr  = m_addr[32*i +: 32];
            sel_wdata = m_wdata[32*i +: 32];
            sel_wstrb = m_wstrb[4*i +: 4];
         end
      end
   end

   // Bus outputs; slave side is quiet outside GRANT so reset/IDLE show zeros
   always_comb begin
      s_valid = 1'b0;
      s_addr  = '0;
      s_wdata = '0;
      s_wstrb = '0;
      m_ready = '0;
      m_rdata = s_rdata;
      if (state == GRANT) begin
         s_valid = sel_valid;
         s_addr  = sel_addr;
         s_wdata = sel_wdata;
         s_wstrb = sel_wstrb;
         for (int i = 0; i < MASTER_CNT; i++)
            if (GW'(i) == g) m_ready[i] = s_ready;
      end
`ifdef ARB_TIMEOUT_EN
      else if (state == ABORT) begin
         m_rdata = 32'hDEADBEEF;
         for (int i = 0; i < MASTER_CNT; i++)
            if (GW'(i) == g) m_ready[i] = 1'b1;
      end
`endif
   end

`ifdef ARB_TIMEOUT_EN
   logic [15:0] stall_cnt;

   // Stall counter: zero outside GRANT, counts GRANT cycles without s_ready
   always_ff @(posedge clk48m) begin
      if (!resetn || state != GRANT) stall_cnt <= '0;
      else if (!s_ready)             stall_cnt <= stall_cnt + 16'd1;
   end

   assign bus_timeout = (state == ABORT);
`else
   assign bus_timeout = 1'b0;
`endif

   // Arbitration FSM; every GRANT returns through IDLE so stale valids are never regranted
   always_ff @(posedge clk48m) begin
      if (!resetn) begin
         state <= IDLE;
         ptr   <= '0;
         g     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  g     <= win;
                  state <= GRANT;
                  if (PRIO_MODE == 0) ptr <= (win == LAST_M) ? '0 : win + GW'(1);
               end
            end
            GRANT: begin
               if (!sel_valid || s_ready) state <= IDLE;
`ifdef ARB_TIMEOUT_EN
               else if (stall_cnt == TMO_LAST) state <= ABORT;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign currmaster = 32'(g);

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: a 4-master round-robin instance driven by a
// randomized reference model plus directed cases, and a 2-master
// fixed-priority instance with directed cases. Timeout behaviour follows
// ARB_TIMEOUT_EN.
module tb_mem_arbiter_rr;

   logic clk48m = 1'b0;
   logic resetn = 1'b0;
   always #5 clk48m = ~clk48m;

   // 4-master round-robin instance
   logic [3:0]   m_valid;
   logic [127:0] m_addr, m_wdata;
   logic [15:0]  m_wstrb;
   logic [3:0]   m_ready;
   logic [31:0]  m_rdata;
   logic         s_valid;
   logic [31:0]  s_addr, s_wdata;
   logic [3:0]   s_wstrb;
   logic         s_ready;
   logic [31:0]  s_rdata;
   logic [31:0]  currmaster;
   logic         bus_timeout;

   mem_arbiter_rr #(.MASTER_CNT(4), .PRIO_MODE(0), .TIMEOUT_CYCLES(16)) dut_rr (
      .clk48m(clk48m), .resetn(resetn),
      .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_ready(m_ready), .m_rdata(m_rdata),
      .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .s_ready(s_ready), .s_rdata(s_rdata),
      .currmaster(currmaster), .bus_timeout(bus_timeout)
   );

   // 2-master fixed-priority instance
   logic [1:0]  p_valid;
   logic [63:0] p_addr, p_wdata;
   logic [7:0]  p_wstrb;
   logic [1:0]  p_ready;
   logic [31:0] p_rdata;
   logic        ps_valid;
   logic [31:0] ps_addr, ps_wdata;
   logic [3:0]  ps_wstrb;
   logic        ps_ready;
   logic [31:0] ps_rdata;
   logic [31:0] p_curr;
   logic        p_tmo;

   mem_arbiter_rr #(.MASTER_CNT(2), .PRIO_MODE(1)) dut_fp (
      .clk48m(clk48m), .resetn(resetn),
      .m_valid(p_valid), .m_addr(p_addr), .m_wdata(p_wdata), .m_wstrb(p_wstrb),
      .m_ready(p_ready), .m_rdata(p_rdata),
      .s_valid(ps_valid), .s_addr(ps_addr), .s_wdata(ps_wdata), .s_wstrb(ps_wstrb),
      .s_ready(ps_ready), .s_rdata(ps_rdata),
      .currmaster(p_curr), .bus_timeout(p_tmo)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk48m);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk48m);
   endtask

   task automatic clear_inputs();
      m_valid = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
      s_ready = 1'b0; s_rdata = '0;
      p_valid = '0; p_addr = '0; p_wdata = '0; p_wstrb = '0;
      ps_ready = 1'b0; ps_rdata = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      resetn = 1'b0;
      tick();
      tick();
      resetn = 1'b1;
   endtask

   // First requesting index scanning circularly from start
   function automatic int pick(input logic [3:0] req, input int start);
      for (int k = 0; k < 4; k++) begin
         int idx;
         idx = (start + k) % 4;
         if (req[idx]) return idx;
      end
      return -1;
   endfunction

   // Randomized traffic on the round-robin instance against a transaction model
   task automatic run_random(input int cycles, input int pct);
      logic [31:0] ma[4], mw[4];
      logic [3:0]  ms[4];
      bit          pend[4], cool[4];
      int          busy, mg, mptr, mcurr, waitc, w;
      logic [3:0]  req;
      do_reset();
      busy = 0; mg = 0; mptr = 0; mcurr = 0; waitc = 0;
      for (int i = 0; i < 4; i++) begin
         pend[i] = 0; cool[i] = 0; ma[i] = '0; mw[i] = '0; ms[i] = '0;
      end
      for (int c = 0; c < cycles; c++) begin
         for (int i = 0; i < 4; i++) begin
            if (cool[i]) cool[i] = 0;
            else if (!pend[i] && $urandom_range(99) < pct) begin
               pend[i] = 1;
               ma[i] = $urandom;
               mw[i] = $urandom;
               ms[i] = 4'($urandom_range(15));
            end
            m_valid[i] = pend[i];
            m_addr[32*i +: 32]  = ma[i];
            m_wdata[32*i +: 32] = mw[i];
            m_wstrb[4*i +: 4]   = ms[i];
         end
         s_ready = busy ? (waitc == 0) : 1'($urandom_range(1));
         s_rdata = $urandom;
         at_neg();
         if (!busy) begin
            check_val("idle_s_valid", 32'(s_valid), 32'd0);
            check_val("idle_m_ready", 32'(m_ready), 32'd0);
            check_val("idle_s_wstrb", 32'(s_wstrb), 32'd0);
            check_val("idle_curr", currmaster, 32'(mcurr));
            for (int i = 0; i < 4; i++) req[i] = pend[i];
            w = pick(req, mptr);
            if (w >= 0) begin
               mg = w; mcurr = w; mptr = (w + 1) % 4;
               busy = 1; waitc = $urandom_range(3);
            end
         end else begin
            check_val("grant_s_valid", 32'(s_valid), 32'd1);
            check_val("grant_s_addr", s_addr, ma[mg]);
            check_val("grant_s_wdata", s_wdata, mw[mg]);
            check_val("grant_s_wstrb", 32'(s_wstrb), 32'(ms[mg]));
            check_val("grant_m_ready", 32'(m_ready), s_ready ? (32'd1 << mg) : 32'd0);
            check_val("grant_m_rdata", m_rdata, s_rdata);
            check_val("grant_curr", currmaster, 32'(mg));
            check_val("grant_tmo", 32'(bus_timeout), 32'd0);
            if (s_ready) begin
               pend[mg] = 0; cool[mg] = 1; busy = 0;
            end else waitc--;
         end
         tick();
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_inputs();
      tick();

      // Reset state
      do_reset();
      at_neg();
      check_val("rst_s_valid", 32'(s_valid), 32'd0);
      check_val("rst_m_ready", 32'(m_ready), 32'd0);
      check_val("rst_s_wstrb", 32'(s_wstrb), 32'd0);
      check_val("rst_curr", currmaster, 32'd0);
      check_val("rst_tmo", 32'(bus_timeout), 32'd0);
      check_val("rst_fp_curr", p_curr, 32'd0);
      tick();

      // Fixed priority: master 0 read with 3 stall cycles
      p_valid = 2'b01; p_addr[31:0] = 32'h40000100; p_addr[63:32] = 32'hA0000004;
      p_wstrb = 8'h00; ps_ready = 1'b0;
      at_neg();
      check_val("fp_idle_valid", 32'(ps_valid), 32'd0);
      tick();
      for (int k = 0; k < 3; k++) begin
         at_neg();
         check_val("fp_stall_valid", 32'(ps_valid), 32'd1);
         check_val("fp_stall_addr", ps_addr, 32'h40000100);
         check_val("fp_stall_ready", 32'(p_ready), 32'd0);
         tick();
      end
      ps_ready = 1'b1; ps_rdata = 32'h12345678;
      at_neg();
      check_val("fp_done_ready", 32'(p_ready), 32'd1);
      check_val("fp_done_rdata", p_rdata, 32'h12345678);
      check_val("fp_done_curr", p_curr, 32'd0);
      tick();
      p_valid = 2'b00; ps_ready = 1'b0;
      at_neg();
      check_val("fp_after_ready", 32'(p_ready), 32'd0);
      check_val("fp_after_valid", 32'(ps_valid), 32'd0);
      tick();

      // Fixed priority: both request continuously, master 0 always wins
      p_valid = 2'b11; ps_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         at_neg();
         if (k % 2 == 0) begin
            check_val("fp_pair_idle", 32'(ps_valid), 32'd0);
         end else begin
            check_val("fp_pair_valid", 32'(ps_valid), 32'd1);
            check_val("fp_pair_ready", 32'(p_ready), 32'd1);
            check_val("fp_pair_curr", p_curr, 32'd0);
         end
         tick();
      end
      p_valid = 2'b10;
      at_neg();
      check_val("fp_m1_idle", 32'(ps_valid), 32'd0);
      tick();
      at_neg();
      check_val("fp_m1_ready", 32'(p_ready), 32'd2);
      check_val("fp_m1_curr", p_curr, 32'd1);
      check_val("fp_m1_addr", ps_addr, 32'hA0000004);
      tick();
      p_valid = 2'b00; ps_ready = 1'b0;

      // Round-robin: last grant 1, then all request -> 2,3,0,1
      do_reset();
      m_valid = 4'b0010; s_ready = 1'b1;
      at_neg();
      tick();
      at_neg();
      check_val("rr_first_curr", currmaster, 32'd1);
      tick();
      m_valid = 4'b1111;
      for (int j = 0; j < 8; j++) begin
         at_neg();
         if (j % 2 == 1) begin
            check_val("rr_order_curr", currmaster, 32'((2 + j/2) % 4));
            check_val("rr_order_ready", 32'(m_ready), 32'd1 << ((2 + j/2) % 4));
         end else begin
            check_val("rr_order_idle", 32'(s_valid), 32'd0);
         end
         tick();
      end

      // Reset during GRANT with a pending write
      do_reset();
      m_valid = 4'b0100; m_wstrb[11:8] = 4'hF; m_addr[95:64] = 32'h00001000; s_ready = 1'b0;
      at_neg();
      tick();
      at_neg();
      check_val("rg_pre_valid", 32'(s_valid), 32'd1);
      check_val("rg_pre_wstrb", 32'(s_wstrb), 32'hF);
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      at_neg();
      check_val("rg_s_valid", 32'(s_valid), 32'd0);
      check_val("rg_s_wstrb", 32'(s_wstrb), 32'd0);
      check_val("rg_m_ready", 32'(m_ready), 32'd0);
      check_val("rg_curr", currmaster, 32'd0);
      m_valid = 4'b1111;
      tick();
      at_neg();
      check_val("rg_next_curr", currmaster, 32'd0);
      check_val("rg_next_valid", 32'(s_valid), 32'd1);
      tick();

      // Stall on master 1
      do_reset();
      m_valid = 4'b0010; s_ready = 1'b0; s_rdata = 32'h55AA55AA;
      at_neg();
      tick();
      for (int k = 0; k < 16; k++) begin
         at_neg();
         check_val("tmo_stall_valid", 32'(s_valid), 32'd1);
         check_val("tmo_stall_ready", 32'(m_ready), 32'd0);
         check_val("tmo_stall_pulse", 32'(bus_timeout), 32'd0);
         tick();
      end
`ifdef ARB_TIMEOUT_EN
      at_neg();
      check_val("tmo_abort_ready", 32'(m_ready), 32'd2);
      check_val("tmo_abort_rdata", m_rdata, 32'hDEADBEEF);
      check_val("tmo_abort_pulse", 32'(bus_timeout), 32'd1);
      check_val("tmo_abort_valid", 32'(s_valid), 32'd0);
      tick();
      m_valid = 4'b0000;
      at_neg();
      check_val("tmo_post_pulse", 32'(bus_timeout), 32'd0);
      check_val("tmo_post_ready", 32'(m_ready), 32'd0);
      tick();

      // s_ready on the limit cycle completes normally
      m_valid = 4'b0010;
      at_neg();
      tick();
      for (int k = 0; k < 15; k++) begin
         at_neg();
         tick();
      end
      s_ready = 1'b1;
      at_neg();
      check_val("lim_ready", 32'(m_ready), 32'd2);
      check_val("lim_rdata", m_rdata, 32'h55AA55AA);
      check_val("lim_pulse", 32'(bus_timeout), 32'd0);
      tick();
      m_valid = 4'b0000; s_ready = 1'b0;
      at_neg();
      check_val("lim_post_pulse", 32'(bus_timeout), 32'd0);
      check_val("lim_post_ready", 32'(m_ready), 32'd0);
      tick();
`else
      for (int k = 0; k < 24; k++) begin
         at_neg();
         check_val("notmo_ready", 32'(m_ready), 32'd0);
         check_val("notmo_valid", 32'(s_valid), 32'd1);
         check_val("notmo_pulse", 32'(bus_timeout), 32'd0);
         tick();
      end
      s_ready = 1'b1;
      at_neg();
      check_val("notmo_done", 32'(m_ready), 32'd2);
      tick();
      m_valid = 4'b0000; s_ready = 1'b0;
`endif

      // Randomized traffic: saturated and sparse request rates
      run_random(1500, 100);
      run_random(1500, 30);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
